// File: rtl/mem_image_loader.sv
// mem_image_loader
//   Host-side loader for the pipeline's external memory-load interface. It accepts a
//   32-bit word stream, packs consecutive words into pairs and drives the instruction
//   and data memory load ports. While it does this it holds enable_load_ex_mem high,
//   which keeps the core in its load state. Once the last pair has been committed,
//   enable drops and the core starts fetching at PC 0.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start                 1-cycle load request, honoured only when idle
//   inst_pairs/data_pairs pair counts, latched at start
//   s_valid/s_data/s_ready word stream (valid/ready handshake)
//   enable_load_ex_mem    core load-mode hold and memory write strobe
//   InstExMem*            instruction pair address and the two words of the pair
//   DataExMem*            data pair address and the two words of the pair
//   busy, done, err       status: loader active, load-finished pulse, bad-count pulse
//
// State   | meaning
// IDLE    | waiting for start, all outputs low
// LD_INST | accepting words for instruction memory pairs
// LD_DATA | accepting words for data memory pairs
// DRAIN   | enable still high so the final pair is committed, then back to IDLE
module mem_image_loader #(
  parameter int PC_W       = 9,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int DRAIN_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PC_W-3:0]       inst_pairs,
  input  logic [DM_ADDRESS-3:0] data_pairs,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  s_ready,
  output logic                  enable_load_ex_mem,
  output logic [PC_W-1:0]       InstExMemAddress,
  output logic [DATA_W-1:0]     InstExMemData1,
  output logic [DATA_W-1:0]     InstExMemData2,
  output logic [DM_ADDRESS-1:0] DataExMemAddress,
  output logic [DATA_W-1:0]     DataExMemData1,
  output logic [DATA_W-1:0]     DataExMemData2,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned INST_MAX = 2 ** (PC_W - 3);
  localparam int unsigned DATA_MAX = 2 ** (DM_ADDRESS - 3);
  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYC);

  typedef enum logic [1:0] {IDLE, LD_INST, LD_DATA, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [PC_W-3:0]       inst_pairs_q, inst_pairs_d;
  logic [DM_ADDRESS-3:0] data_pairs_q, data_pairs_d;
  logic [PC_W-3:0]       inst_cnt_q, inst_cnt_d;
  logic [DM_ADDRESS-3:0] data_cnt_q, data_cnt_d;
  logic                  phase_q, phase_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [3:0]            drain_cnt_q, drain_cnt_d;
  logic                  s_ready_q, s_ready_d;
  logic                  enable_q, enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [PC_W-1:0]       inst_addr_q, inst_addr_d;
  logic [DATA_W-1:0]     inst_data1_q, inst_data1_d;
  logic [DATA_W-1:0]     inst_data2_q, inst_data2_d;
  logic [DM_ADDRESS-1:0] data_addr_q, data_addr_d;
  logic [DATA_W-1:0]     data_data1_q, data_data1_d;
  logic [DATA_W-1:0]     data_data2_q, data_data2_d;

  logic                  accept;
  logic                  counts_bad;
  logic [PC_W-3:0]       inst_cnt_inc;
  logic [DM_ADDRESS-3:0] data_cnt_inc;

  // s_ready_q is high exactly in the load states, so this is the handshake.
  assign accept       = s_valid && s_ready_q;
  assign counts_bad   = (32'(inst_pairs) > INST_MAX) || (32'(data_pairs) > DATA_MAX);
  assign inst_cnt_inc = inst_cnt_q + (PC_W - 2)'(1);
  assign data_cnt_inc = data_cnt_q + (DM_ADDRESS - 2)'(1);

  always_comb begin
    state_d      = state_q;
    inst_pairs_d = inst_pairs_q;
    data_pairs_d = data_pairs_q;
    inst_cnt_d   = inst_cnt_q;
    data_cnt_d   = data_cnt_q;
    phase_d      = phase_q;
    lo_d         = lo_q;
    drain_cnt_d  = drain_cnt_q;
    inst_addr_d  = inst_addr_q;
    inst_data1_d = inst_data1_q;
    inst_data2_d = inst_data2_q;
    data_addr_d  = data_addr_q;
    data_data1_d = data_data1_q;
    data_data2_d = data_data2_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (counts_bad) begin
            err_d = 1'b1;
          end else begin
            inst_pairs_d = inst_pairs;
            data_pairs_d = data_pairs;
            inst_cnt_d   = '0;
            data_cnt_d   = '0;
            phase_d      = 1'b0;
            lo_d         = '0;
            drain_cnt_d  = DRAIN_LOAD;
            inst_addr_d  = '0;
            inst_data1_d = '0;
            inst_data2_d = '0;
            data_addr_d  = '0;
            data_data1_d = '0;
            data_data2_d = '0;
            if (inst_pairs != '0)      state_d = LD_INST;
            else if (data_pairs != '0) state_d = LD_DATA;
            else                       state_d = DRAIN;
          end
        end
      end

      LD_INST: begin
        if (accept) begin
          if (!phase_q) begin
            lo_d    = s_data;
            phase_d = 1'b1;
          end else begin
            phase_d      = 1'b0;
            inst_addr_d  = {inst_cnt_q[PC_W-4:0], 3'b000};
            inst_data1_d = lo_q;
            inst_data2_d = s_data;
            inst_cnt_d   = inst_cnt_inc;
            if (inst_cnt_inc == inst_pairs_q) begin
              if (data_pairs_q != '0) begin
                state_d = LD_DATA;
              end else begin
                state_d     = DRAIN;
                drain_cnt_d = DRAIN_LOAD;
              end
            end
          end
        end
      end

      LD_DATA: begin
        if (accept) begin
          if (!phase_q) begin
            lo_d    = s_data;
            phase_d = 1'b1;
          end else begin
            phase_d      = 1'b0;
            data_addr_d  = {data_cnt_q[DM_ADDRESS-4:0], 3'b000};
            data_data1_d = lo_q;
            data_data2_d = s_data;
            data_cnt_d   = data_cnt_inc;
            if (data_cnt_inc == data_pairs_q) begin
              state_d     = DRAIN;
              drain_cnt_d = DRAIN_LOAD;
            end
          end
        end
      end

      DRAIN: begin
        // The state itself lasts DRAIN_CYC+1 cycles: the cycle carrying the
        // final pair plus DRAIN_CYC commit cycles.
        if (drain_cnt_q == 4'd0) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          inst_addr_d  = '0;
          inst_data1_d = '0;
          inst_data2_d = '0;
          data_addr_d  = '0;
          data_data1_d = '0;
          data_data2_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == LD_INST) || (state_d == LD_DATA);
    enable_d  = (state_d != IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      inst_pairs_q <= '0;
      data_pairs_q <= '0;
      inst_cnt_q   <= '0;
      data_cnt_q   <= '0;
      phase_q      <= 1'b0;
      lo_q         <= '0;
      drain_cnt_q  <= '0;
      s_ready_q    <= 1'b0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      inst_addr_q  <= '0;
      inst_data1_q <= '0;
      inst_data2_q <= '0;
      data_addr_q  <= '0;
      data_data1_q <= '0;
      data_data2_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_pairs_q <= inst_pairs_d;
      data_pairs_q <= data_pairs_d;
      inst_cnt_q   <= inst_cnt_d;
      data_cnt_q   <= data_cnt_d;
      phase_q      <= phase_d;
      lo_q         <= lo_d;
      drain_cnt_q  <= drain_cnt_d;
      s_ready_q    <= s_ready_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      inst_addr_q  <= inst_addr_d;
      inst_data1_q <= inst_data1_d;
      inst_data2_q <= inst_data2_d;
      data_addr_q  <= data_addr_d;
      data_data1_q <= data_data1_d;
      data_data2_q <= data_data2_d;
    end
  end

  assign s_ready            = s_ready_q;
  assign enable_load_ex_mem = enable_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign InstExMemAddress   = inst_addr_q;
  assign InstExMemData1     = inst_data1_q;
  assign InstExMemData2     = inst_data2_q;
  assign DataExMemAddress   = data_addr_q;
  assign DataExMemData1     = data_data1_q;
  assign DataExMemData2     = data_data2_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader
//   Drives word streams into mem_image_loader and models the two load memories: every
//   cycle enable is high, the driven pair is written into a behavioural memory. The
//   final memory contents are compared with the image built directly from the stream.
module tb_mem_image_loader;

  localparam int PC_W       = 9;
  localparam int DM_ADDRESS = 9;
  localparam int DATA_W     = 32;
  localparam int DRAIN_CYC  = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [PC_W-3:0]       inst_pairs;
  logic [DM_ADDRESS-3:0] data_pairs;
  logic                  s_valid;
  logic [DATA_W-1:0]     s_data;
  logic                  s_ready;
  logic                  enable_load_ex_mem;
  logic [PC_W-1:0]       InstExMemAddress;
  logic [DATA_W-1:0]     InstExMemData1;
  logic [DATA_W-1:0]     InstExMemData2;
  logic [DM_ADDRESS-1:0] DataExMemAddress;
  logic [DATA_W-1:0]     DataExMemData1;
  logic [DATA_W-1:0]     DataExMemData2;
  logic                  busy;
  logic                  done;
  logic                  err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] stim_q [$];

  mem_image_loader #(
    .PC_W(PC_W), .DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .inst_pairs(inst_pairs), .data_pairs(data_pairs),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .enable_load_ex_mem(enable_load_ex_mem),
    .InstExMemAddress(InstExMemAddress), .InstExMemData1(InstExMemData1),
    .InstExMemData2(InstExMemData2),
    .DataExMemAddress(DataExMemAddress), .DataExMemData1(DataExMemData1),
    .DataExMemData2(DataExMemData2),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out_nz();
    return |{InstExMemAddress, InstExMemData1, InstExMemData2,
             DataExMemAddress, DataExMemData1, DataExMemData2};
  endfunction

  // One complete load. Words come from stim_q (topped up with random words).
  // mode: 0 = s_valid always high, 1 = toggling, 2 = random.
  task automatic run_load(input int ni, input int nd, input int mode, input bit poke_start);
    logic [31:0] w [$];
    logic [31:0] imem [128];
    logic [31:0] dmem [128];
    int total, acc, cyc, tail_en, viol, bad_i, bad_d, done_seen, max_ia, idx;
    logic [31:0] last_i1, last_i2, last_d1, last_d2;
    int last_ia, last_da;
    bit tog;

    total = 2 * (ni + nd);
    w = stim_q;
    stim_q.delete();
    while (w.size() < total) w.push_back($urandom);
    for (int i = 0; i < 128; i++) begin
      imem[i] = 32'hDEAD_BEEF;
      dmem[i] = 32'hDEAD_BEEF;
    end

    inst_pairs = 7'(ni);
    data_pairs = 7'(nd);
    start = 1'b1;
    tick();
    start = 1'b0;
    inst_pairs = 7'($urandom);
    data_pairs = 7'($urandom);
    chk_eq("start_resp", {enable_load_ex_mem, busy, any_out_nz()}, 3'b110);

    acc = 0; cyc = 0; tail_en = 0; viol = 0; done_seen = 0; max_ia = 0; tog = 1'b0;
    last_i1 = 0; last_i2 = 0; last_d1 = 0; last_d2 = 0; last_ia = 0; last_da = 0;
    while (!done_seen && cyc < 4000) begin
      if (done) begin
        done_seen = 1;
        chk_eq("done_state", {enable_load_ex_mem, busy, s_ready, err, any_out_nz()}, 5'b0);
      end else begin
        if (!enable_load_ex_mem || !busy) viol++;
        if (err) viol++;
        if (s_ready != (acc < total)) viol++;
        if (acc < 2 * ni + 2 && (|{DataExMemAddress, DataExMemData1, DataExMemData2})) viol++;
        if (acc == total && enable_load_ex_mem) tail_en++;
        if (enable_load_ex_mem) begin
          idx = int'(InstExMemAddress) / 4;
          if (idx < 127) begin
            imem[idx] = InstExMemData1;
            imem[idx+1] = InstExMemData2;
          end
          idx = int'(DataExMemAddress) / 4;
          if (idx < 127) begin
            dmem[idx] = DataExMemData1;
            dmem[idx+1] = DataExMemData2;
          end
          if (int'(InstExMemAddress) > max_ia) max_ia = int'(InstExMemAddress);
          last_i1 = InstExMemData1; last_i2 = InstExMemData2; last_ia = int'(InstExMemAddress);
          last_d1 = DataExMemData1; last_d2 = DataExMemData2; last_da = int'(DataExMemAddress);
        end
        case (mode)
          0:       s_valid = 1'b1;
          1:       s_valid = tog;
          default: s_valid = 1'($urandom_range(0, 1));
        endcase
        tog = !tog;
        s_data = (s_valid && acc < total) ? w[acc] : $urandom;
        if (s_valid && s_ready) acc++;
        start = poke_start && (cyc == 20);
        if (start) begin
          inst_pairs = 7'd1;
          data_pairs = 7'd1;
        end
        tick();
        cyc++;
      end
    end
    s_valid = 1'b0;
    start = 1'b0;

    chk_eq("done_seen", done_seen, 1);
    chk_eq("words_accepted", acc, total);
    chk_eq("cycle_rules", viol, 0);
    chk_eq("drain_len", tail_en, 1 + DRAIN_CYC);
    bad_i = 0;
    bad_d = 0;
    for (int k = 0; k < 2 * ni; k++) if (imem[k] !== w[k]) bad_i++;
    for (int k = 0; k < 2 * nd; k++) if (dmem[k] !== w[2*ni+k]) bad_d++;
    chk_eq("inst_image", bad_i, 0);
    chk_eq("data_image", bad_d, 0);
    if (ni > 0) begin
      chk_eq("inst_max_addr", max_ia, 8 * (ni - 1));
      chk_eq("inst_hold_addr", last_ia, 8 * (ni - 1));
      chk_eq("inst_hold_data", {last_i1, last_i2}, {w[2*ni-2], w[2*ni-1]});
    end
    if (nd > 0) begin
      chk_eq("data_hold_addr", last_da, 8 * (nd - 1));
      chk_eq("data_hold_data", {last_d1, last_d2}, {w[total-2], w[total-1]});
    end
    tick();
    chk_eq("done_width", done, 1'b0);
  endtask

  initial begin
    int ni, nd;
    reset = 1'b1; start = 1'b0; inst_pairs = '0; data_pairs = '0;
    s_valid = 1'b0; s_data = '0;
    tick(); tick();
    chk_eq("reset_state",
           {enable_load_ex_mem, busy, s_ready, done, err, any_out_nz()}, 6'b0);
    reset = 1'b0;
    tick();

    // Reset in the middle of an instruction load, then reload from address 0.
    inst_pairs = 7'd2; data_pairs = 7'd0; start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = $urandom;
      tick();
    end
    s_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk_eq("mid_reset",
           {enable_load_ex_mem, busy, s_ready, done, err, any_out_nz()}, 6'b0);
    reset = 1'b0;
    run_load(2, 1, 0, 1'b0);

    // Small program image.
    stim_q = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};
    run_load(2, 0, 0, 1'b0);

    // One pair each with a toggling stream.
    stim_q = '{32'h0000_00A1, 32'h0000_00A2, 32'h0000_00D1, 32'h0000_00D2};
    run_load(1, 1, 1, 1'b0);

    // Empty image: only the drain window.
    run_load(0, 0, 2, 1'b0);

    // Out-of-range counts.
    inst_pairs = 7'd65; data_pairs = 7'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_eq("err_inst", {err, busy, enable_load_ex_mem}, 3'b100);
    tick();
    chk_eq("err_pulse", {err, busy, enable_load_ex_mem}, 3'b000);
    inst_pairs = 7'd3; data_pairs = 7'd65; start = 1'b1;
    tick();
    start = 1'b0;
    chk_eq("err_data", {err, busy, enable_load_ex_mem}, 3'b100);
    tick();

    // Full instruction memory with a stray start mid-load, then full data memory.
    run_load(64, 0, 2, 1'b1);
    run_load(0, 64, 2, 1'b0);

    for (int r = 0; r < 6; r++) begin
      ni = $urandom_range(0, 20);
      nd = $urandom_range(0, 20);
      run_load(ni, nd, $urandom_range(0, 2), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
